sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Sequences every data-memory access of the MEM stage onto a 16-bit external SRAM with a fixed wait-state count per half-word, and produces the `ready` signal the pipeline uses as its freeze source (`freeze = ~ready`). It sits between the MEM-stage ALU result/store data and the SRAM pins. While `ready` is low it holds the MEM stage register and everything upstream. A 32-bit access is split into a low half-word transfer followed by a high half-word transfer.

## Interface
- `WAIT_CYCLES`, 2: cycles each half-word phase is held on the SRAM pins (≥1).
- `ADDR_BASE`, 1024: byte address mapped to SRAM half-word 0.
- `SRAM_AW`, 18: SRAM half-word address width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_en` in 1: load request from MEM stage.
- `wr_en` in 1: store request from MEM stage.
- `address` in 32: byte address, word aligned.
- `wdata` in 32: store data.
- `rdata` out 32: load data, registered.
- `ready` out 1: access complete or no access pending.
- `sram_addr` out SRAM_AW: half-word address.
- `sram_dq_out` out 16: write data to pins.
- `sram_dq_oe` out 1: drive enable for dq.
- `sram_dq_in` in 16: read data from pins.
- `sram_we_n` out 1: active-low write enable.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - `ready = ~(rd_en | wr_en)`, except on a read-buffer hit (see Configuration).
  - On a request, latch `{address, wdata, is_write}`, load the counter with WAIT_CYCLES-1, and go to LO.
- `wr_en` has priority when both requests are high; the access is then a write.
- Address mapping: `word = (address - ADDR_BASE) >> 2`.
  - LO drives `sram_addr = {word, 1'b0}`.
  - HI drives `sram_addr = {word, 1'b1}`.
  - Both are truncated modulo 2^SRAM_AW. There is no range error.
- LO and HI each last WAIT_CYCLES cycles.
  - The counter decrements every cycle; the phase ends when it reaches 0, and HI reloads it.
- Write phases:
  - `sram_we_n = 0` and `sram_dq_oe = 1`.
  - `sram_dq_out` is `wdata[15:0]` in LO and `wdata[31:16]` in HI.
- Read phases:
  - `sram_we_n = 1` and `sram_dq_oe = 0`.
  - `sram_dq_in` is captured on the last cycle of LO into `rdata[15:0]`, and on the last cycle of HI into `rdata[31:16]`.
- DONE lasts one cycle with `ready = 1`, then the block returns to IDLE unconditionally.
  - Requests present during DONE are ignored; they belong to the instruction being released.
- `rdata` holds its value until the next completed read. Writes do not alter `rdata`.
- The requester keeps `address`, `wdata`, `rd_en` and `wr_en` stable while `ready = 0`. The block uses only its latched copies.
- Outside LO/HI: `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`.

## Timing
- Reset values: state IDLE, `rdata = 0`, `sram_we_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`, read buffer invalid.
  - `ready` is combinational and equals 1 while `rst` is high.
- Miss latency:
  - Request seen in IDLE at cycle 0.
  - LO covers cycles 1..W; HI covers cycles W+1..2W.
  - DONE at cycle 2W+1, where `ready = 1` and `rdata` is valid.
  - `ready` is low for 2W+1 cycles (cycles 0..2W).
- Back-to-back accesses: the next request is taken in IDLE at cycle 2W+2.
- Reset mid-access aborts immediately. The SRAM pins return to their idle values in the same cycle, and the partial `rdata` is cleared to 0.

## Configuration
- Macro `SRAM_CTRL_READ_BUF_EN`.
- Defined:
  - A one-entry buffer holds the tag (`address`) and a valid bit of the last completed read; the data is `rdata`.
  - A read in IDLE whose `address` equals the tag, with valid set, is a hit: `ready = 1` in the same cycle, `rdata` is unchanged, and the SRAM is not accessed.
  - Any write to the tag address clears valid when the write enters DONE.
- Undefined: every access misses, and there is no tag or valid logic.

## Structure
- Shared package or header `sram_ctrl_pkg`: state encoding constants (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3) and the default `ADDR_BASE`/`WAIT_CYCLES` values.
- One sub-module, `wait_counter`: a loadable down-counter with a `zero` flag, sized `$clog2(WAIT_CYCLES)+1`.
- FSM, address mapping and read buffer stay in `sram_access_ctrl`.

## Test plan
- Read miss, W=2, `address=1024`, `sram_dq_in` = 16'hBEEF in LO and 16'hDEAD in HI → `ready` low for cycles 0–4, `rdata=32'hDEADBEEF` with `ready=1` at cycle 5, `sram_addr` = 0 then 1.
- Write, `address=1032`, `wdata=32'h12345678` → `sram_we_n=0` for 4 cycles, with `sram_addr`/`sram_dq_out` = 4/16'h5678 then 5/16'h1234; `rdata` unchanged.
- `rd_en` and `wr_en` both high → write performed, no read capture.
- Reset asserted at cycle 2 of a read → same cycle: `sram_we_n=1`, `sram_dq_oe=0`, `rdata=0`; after release, `ready=1` and state is IDLE.
- With `SRAM_CTRL_READ_BUF_EN`: repeat a read of 1024 → `ready=1` in cycle 0 with `rdata` unchanged. Then a write to 1024 followed by a read of 1024 → full 5-cycle miss.
- Back-to-back reads of 1024 and 1028 → second access starts at cycle 6, with no request taken during DONE.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access controller: FSM state encoding
// and default parameter values.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned DEF_ADDR_BASE   = 1024;
    localparam int unsigned DEF_SRAM_AW     = 18;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Bus bundle between the MEM stage, the SRAM access controller and the SRAM pins.
// Handshake: the requester raises rd_en or wr_en and holds address, wdata
// and the request stable while ready is low; the access is complete in the
// first cycle ready is high (rdata is valid there for a read).
interface sram_access_ctrl_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;

    modport master (
        output rd_en, wr_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_access_ctrl_wait_counter.sv
// Loadable down-counter that times each half-word phase; zero marks the
// last cycle of a phase. It stops at zero rather than wrapping.
module wait_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] cnt;

    // Load takes precedence over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sram_access_ctrl.sv
// MEM-stage data access sequencer for a 16-bit SRAM. Each 32-bit access is
// split into a low and a high half-word phase, each held WAIT_CYCLES cycles.
// ready doubles as the pipeline freeze source (freeze = ~ready).
// Optional feature: define SRAM_CTRL_READ_BUF_EN for a one-entry read buffer
// that answers a repeated read of the last read address in zero cycles.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic                clk,
    input  logic                rst,
    sram_access_ctrl_if.slave   bus,
    output state_t              state_dbg
);
    localparam int unsigned    CW     = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0]  RELOAD = CW'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_write;
    logic [31:0] rdata_q;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        take;
    logic        ready_fsm;
    logic        pins_on;
    logic        phase_hi;
    logic        hit;

    wait_counter #(.WIDTH(CW)) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

`ifdef SRAM_CTRL_READ_BUF_EN
    logic [31:0] tag_q;
    logic        valid_q;

    // A plain read (not a combined read/write) of the buffered address skips the SRAM.
    assign hit = (state == IDLE) && valid_q && bus.rd_en && !bus.wr_en &&
                 (bus.address == tag_q);

    // Record each completed read; a write to the buffered address invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if ((state == HI) && cnt_zero) begin
            if (!lat_write) begin
                tag_q   <= lat_addr;
                valid_q <= 1'b1;
            end else if (lat_addr == tag_q) begin
                valid_q <= 1'b0;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter control and phase decode.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        take      = 1'b0;
        ready_fsm = 1'b0;
        pins_on   = 1'b0;
        phase_hi  = 1'b0;
        case (state)
            IDLE: begin
                ready_fsm = !(bus.rd_en || bus.wr_en) || hit;
                if ((bus.rd_en || bus.wr_en) && !hit) begin
                    take      = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                pins_on = 1'b1;
                if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    state_nxt = HI;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HI: begin
                pins_on  = 1'b1;
                phase_hi = 1'b1;
                if (cnt_zero) begin
                    state_nxt = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                // Requests seen here belong to the instruction being released.
                ready_fsm = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request; wr_en wins when both requests are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if (take) begin
            lat_addr  <= bus.address;
            lat_wdata <= bus.wdata;
            lat_write <= bus.wr_en;
        end
    end

    // Read data is sampled on the last cycle of each read phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (pins_on && cnt_zero && !lat_write) begin
            if (phase_hi) begin
                rdata_q[31:16] <= bus.sram_dq_in;
            end else begin
                rdata_q[15:0] <= bus.sram_dq_in;
            end
        end
    end

    // Pins follow the state directly so a reset idles them in the same cycle.
    assign bus.sram_we_n   = !(pins_on && lat_write);
    assign bus.sram_dq_oe  = pins_on && lat_write;
    assign bus.sram_dq_out = (pins_on && lat_write) ?
                             (phase_hi ? lat_wdata[31:16] : lat_wdata[15:0]) : 16'h0000;
    assign bus.sram_addr   = pins_on ?
                             SRAM_AW'({(lat_addr - 32'(ADDR_BASE)) >> 2, phase_hi}) : '0;
    assign bus.rdata       = rdata_q;
    assign bus.ready       = rst || ready_fsm;
    assign state_dbg       = state;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: cycle-by-cycle pin checks per access plus an
// expected-rdata queue filled when an access is issued and drained at DONE.
module tb_sram_access_ctrl;
    import sram_ctrl_pkg::*;

    localparam int unsigned W    = 2;
    localparam int unsigned BASE = 1024;
    localparam int unsigned AW   = 18;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state_dbg;

    always #5 clk = ~clk;

    sram_access_ctrl_if #(.SRAM_AW(AW)) bus ();

    sram_access_ctrl #(
        .WAIT_CYCLES (W),
        .ADDR_BASE   (BASE),
        .SRAM_AW     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata = '0;
    logic [31:0] tb_tag      = '0;
    logic        tb_valid    = 1'b0;
    int          n_total     = 0;
    int          n_bad       = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1; drives cycle 0 of the access.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [15:0] lo,
                             input logic [15:0] hi, input bit b2b,
                             input logic [31:0] b2b_addr);
        bit          hit;
        bit          hi_ph;
        logic [31:0] word;
        logic [31:0] exp;
        hit = 1'b0;
`ifdef SRAM_CTRL_READ_BUF_EN
        hit = rd && !wr && tb_valid && (addr == tb_tag);
`endif
        word = (addr - BASE) >> 2;
        if (wr || hit) exp_q.push_back(model_rdata);
        else           exp_q.push_back({hi, lo});

        bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.wdata = wd;
        bus.sram_dq_in = 16'h0000;
        @(negedge clk);
        check("c0_ready", 32'(bus.ready), 32'(hit));
        check("c0_state", 32'(state_dbg), 32'(IDLE));
        if (hit) begin
            exp = exp_q.pop_front();
            check("hit_rdata", bus.rdata, exp);
            check("hit_we_n", 32'(bus.sram_we_n), 32'd1);
            @(posedge clk); #1;
            bus.rd_en = 1'b0;
            @(negedge clk);
            check("hit_state", 32'(state_dbg), 32'(IDLE));
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;

        for (int c = 1; c <= 2 * W; c++) begin
            hi_ph = (c > W);
            bus.sram_dq_in = hi_ph ? hi : lo;
            @(negedge clk);
            check("ph_ready", 32'(bus.ready), 32'd0);
            check("ph_addr", 32'(bus.sram_addr), 32'(AW'(word * 2 + 32'(hi_ph))));
            check("ph_we_n", 32'(bus.sram_we_n), 32'(!wr));
            check("ph_oe", 32'(bus.sram_dq_oe), 32'(wr));
            if (wr) check("ph_dq_out", 32'(bus.sram_dq_out), 32'(hi_ph ? wd[31:16] : wd[15:0]));
            @(posedge clk); #1;
        end

        bus.sram_dq_in = 16'h0000;
        if (b2b) begin
            bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = b2b_addr;
        end else begin
            bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        end
        @(negedge clk);
        check("done_ready", 32'(bus.ready), 32'd1);
        check("done_state", 32'(state_dbg), 32'(DONE));
        check("done_we_n", 32'(bus.sram_we_n), 32'd1);
        check("done_addr", 32'(bus.sram_addr), 32'd0);
        exp = exp_q.pop_front();
        check("done_rdata", bus.rdata, exp);
        model_rdata = exp;
        if (!wr) begin
            tb_tag = addr; tb_valid = 1'b1;
        end else if (addr == tb_tag) begin
            tb_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = BASE; bus.wdata = '0;
        bus.sram_dq_in = '0;

        // Reset values (a request is already pending; ready must still be 1).
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("rst_addr", 32'(bus.sram_addr), 32'd0);
        check("rst_dq_out", 32'(bus.sram_dq_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.rd_en = 1'b0;
        @(posedge clk); #1;

        // Read miss, then a repeat read (hit when the buffer is built in).
        do_access(1, 0, 32'd1024, 32'h0, 16'hBEEF, 16'hDEAD, 0, 32'h0);
        do_access(1, 0, 32'd1024, 32'h0, 16'hCAFE, 16'hF00D, 0, 32'h0);
        // Write, then combined request (write wins), then read after invalidation.
        do_access(0, 1, 32'd1032, 32'h12345678, 16'h0, 16'h0, 0, 32'h0);
        do_access(1, 1, 32'd1024, 32'hA5A55A5A, 16'h7777, 16'h8888, 0, 32'h0);
        do_access(1, 0, 32'd1024, 32'h0, 16'h0123, 16'h4567, 0, 32'h0);
        // Back-to-back reads; the second request is already up during DONE.
        do_access(0, 1, 32'd1024, 32'h0BADF00D, 16'h0, 16'h0, 0, 32'h0);
        do_access(1, 0, 32'd1024, 32'h0, 16'h1357, 16'h2468, 1, 32'd1028);
        do_access(1, 0, 32'd1028, 32'h0, 16'h9ABC, 16'hDEF0, 0, 32'h0);

        // Randomised accesses over a small window so hits and invalidations occur.
        for (int i = 0; i < 8; i++) begin
            bit          rwr;
            logic [31:0] raddr;
            rwr   = 1'($urandom_range(0, 1));
            raddr = BASE + 4 * $urandom_range(0, 3);
            do_access(!rwr, rwr, raddr, $urandom, 16'($urandom), 16'($urandom), 0, 32'h0);
        end

        // Make rdata nonzero, then reset in cycle 2 of a read.
        do_access(1, 0, 32'd1100, 32'h0, 16'h1111, 16'h2222, 0, 32'h0);
        bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = 32'd1036;
        @(posedge clk); #1;
        bus.sram_dq_in = 16'h3333;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check("mid_rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("mid_rst_rdata", bus.rdata, 32'd0);
        check("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        bus.rd_en = 1'b0;
        model_rdata = '0; tb_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready), 32'd1);
        check("post_rst_state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk); #1;

        do_access(1, 0, 32'd1036, 32'h0, 16'h4444, 16'h5555, 0, 32'h0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
